// File: rtl/controller_multicycle_pkg.sv
// Shared types and encodings for the RV32I multicycle controller: FSM states, opcodes,
// ALU/immediate/PC-source/write-back selects and the opcode classifier.
package controller_multicycle_pkg;

    typedef enum logic [2:0] {
        CS_FETCH     = 3'd0,
        CS_DECODE    = 3'd1,
        CS_EXECUTE   = 3'd2,
        CS_MEMORY    = 3'd3,
        CS_WRITEBACK = 3'd4,
        CS_TRAP      = 3'd5
    } ctrl_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_OR   = 4'd9;
    localparam logic [3:0] ALU_AND  = 4'd10;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_ALU = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_OP      = 4'd1,
        CLS_OP_IMM  = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JALR    = 4'd7,
        CLS_LUI     = 4'd8,
        CLS_AUIPC   = 4'd9,
        CLS_FENCE   = 4'd10,
        CLS_SYSTEM  = 4'd11
    } instr_class_t;

    function automatic instr_class_t classify(input logic [6:0] opcode);
        instr_class_t cls;
        case (opcode)
            OPC_OP:     cls = CLS_OP;
            OPC_OP_IMM: cls = CLS_OP_IMM;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_FENCE:  cls = CLS_FENCE;
            OPC_SYSTEM: cls = CLS_SYSTEM;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/controller_multicycle_alu_decoder.sv
// Combinational ALU-function decode and funct3/funct7 legality check for one instruction class.
module controller_multicycle_alu_decoder
    import controller_multicycle_pkg::*;
(
    input  instr_class_t i_class,
    input  logic [2:0]   i_funct3,
    input  logic [6:0]   i_funct7,
    output logic [3:0]   o_alu_function,
    output logic         o_legal
);

    logic w_f7_zero;
    logic w_f7_alt;

    assign w_f7_zero = (i_funct7 == 7'b0000000);
    assign w_f7_alt  = (i_funct7 == 7'b0100000);

    always_comb begin
        o_alu_function = ALU_ADD;
        o_legal        = 1'b1;
        case (i_class)
            CLS_OP, CLS_OP_IMM: begin
                case (i_funct3)
                    3'b000:  o_alu_function = (i_class == CLS_OP && i_funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alu_function = ALU_SLL;
                    3'b010:  o_alu_function = ALU_SLT;
                    3'b011:  o_alu_function = ALU_SLTU;
                    3'b100:  o_alu_function = ALU_XOR;
                    3'b101:  o_alu_function = i_funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  o_alu_function = ALU_OR;
                    default: o_alu_function = ALU_AND;
                endcase
                // OP-IMM only constrains funct7 on shifts, where it carries the shift type.
                if (i_class == CLS_OP) begin
                    o_legal = w_f7_zero || (w_f7_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101));
                end else if (i_funct3 == 3'b001) begin
                    o_legal = w_f7_zero;
                end else if (i_funct3 == 3'b101) begin
                    o_legal = w_f7_zero || w_f7_alt;
                end
            end
            CLS_BRANCH: begin
                o_alu_function = i_funct3[2] ? (i_funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                o_legal        = (i_funct3[2:1] != 2'b01);
            end
            CLS_LOAD: begin
                o_legal = (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            CLS_STORE: begin
                o_legal = (i_funct3 inside {3'b000, 3'b001, 3'b010});
            end
            CLS_JALR: begin
                o_legal = (i_funct3 == 3'b000);
            end
            CLS_FENCE: begin
                o_alu_function = ALU_NONE;
                o_legal        = (i_funct3 == 3'b000 || i_funct3 == 3'b001);
            end
            CLS_SYSTEM: begin
                o_alu_function = ALU_NONE;
                o_legal        = (i_funct3 == 3'b000);
            end
            CLS_JAL, CLS_LUI, CLS_AUIPC: begin
                o_alu_function = ALU_ADD;
            end
            default: begin
                o_alu_function = ALU_NONE;
                o_legal        = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/controller_multicycle.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK) driving the data path.
// Optional ILLEGAL_TRAP_EN: illegal instructions halt in TRAP and raise sticky illegal_o.
module controller_multicycle
    import controller_multicycle_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instruction_i,
    input  logic        zero_i,
    input  logic        lt_i,
    input  logic        imem_valid_i,
    input  logic        dmem_ready_i,
    output logic        imem_req_o,
    output logic        ir_load_o,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic        reg_write_enable_o,
    output logic [1:0]  wb_sel_o,
    output logic        alu_src_1_o,
    output logic        alu_src_2_o,
    output logic [2:0]  imm_gen_sel_o,
    output logic [3:0]  alu_function_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [2:0]  dmem_size_o,
    output logic        instr_retired_o,
    output logic        bus_error_o,
`ifdef ILLEGAL_TRAP_EN
    output logic        illegal_o,
`endif
    output logic [2:0]  dbg_state_o
);

    localparam logic [2:0] ST_FETCH     = CS_FETCH;
    localparam logic [2:0] ST_DECODE    = CS_DECODE;
    localparam logic [2:0] ST_EXECUTE   = CS_EXECUTE;
    localparam logic [2:0] ST_MEMORY    = CS_MEMORY;
    localparam logic [2:0] ST_WRITEBACK = CS_WRITEBACK;
    localparam logic [2:0] ST_TRAP      = CS_TRAP;

    localparam bit          TMO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(MEM_TIMEOUT - 1) : 16'd0;

    logic [2:0]   r_state;
    logic [2:0]   w_next_state;
    logic [15:0]  r_wait_cnt;
    logic         r_bus_error;
    instr_class_t w_class;
    logic [2:0]   w_funct3;
    logic [3:0]   w_alu_fn;
    logic         w_legal;
    logic         w_waiting;
    logic         w_ready;
    logic         w_timeout;
    logic         w_taken;
    logic         w_operands_on;
    logic         w_src1;
    logic         w_src2;
    logic [2:0]   w_imm_sel;
    logic [1:0]   w_wb_sel;
    logic [1:0]   w_jump_src;
    logic         w_unused_bits;

    assign w_class       = classify(instruction_i[6:0]);
    assign w_funct3      = instruction_i[14:12];
    assign w_unused_bits = ^{instruction_i[24:15], instruction_i[11:7]};

    controller_multicycle_alu_decoder u_alu_decoder (
        .i_class        (w_class),
        .i_funct3       (w_funct3),
        .i_funct7       (instruction_i[31:25]),
        .o_alu_function (w_alu_fn),
        .o_legal        (w_legal)
    );

    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEMORY);
    assign w_ready   = (r_state == ST_FETCH) ? imem_valid_i : dmem_ready_i;
    // A ready arriving in the last allowed wait cycle completes normally.
    assign w_timeout = TMO_EN && w_waiting && !w_ready && (r_wait_cnt == TMO_LAST);
    assign w_taken   = (w_funct3[2] ? lt_i : zero_i) ^ w_funct3[0];
    assign w_operands_on = (r_state == ST_DECODE) || (r_state == ST_EXECUTE) ||
                           (r_state == ST_MEMORY) || (r_state == ST_WRITEBACK);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (imem_valid_i) w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_legal) begin
                    w_next_state = ST_EXECUTE;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next_state = ST_TRAP;
`else
                    w_next_state = ST_FETCH;
`endif
                end
            end
            ST_EXECUTE: begin
                case (w_class)
                    CLS_LOAD, CLS_STORE:                w_next_state = ST_MEMORY;
                    CLS_BRANCH, CLS_FENCE, CLS_SYSTEM:  w_next_state = ST_FETCH;
                    default:                            w_next_state = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                if (dmem_ready_i) begin
                    w_next_state = (w_class == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
                end else if (w_timeout) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_WRITEBACK: w_next_state = ST_FETCH;
            ST_TRAP:      w_next_state = ST_TRAP;
            default:      w_next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_FETCH;
            r_wait_cnt  <= 16'd0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // A timed-out fetch stays in FETCH, so it must restart the count explicitly.
            if (w_next_state != r_state || w_timeout) begin
                r_wait_cnt <= 16'd0;
            end else if (w_waiting && r_wait_cnt != 16'hFFFF) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_timeout) r_bus_error <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_illegal <= 1'b0;
        end else if (r_state == ST_DECODE && !w_legal) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal_o = r_illegal;
`endif

    always_comb begin
        w_src1     = 1'b0;
        w_src2     = 1'b0;
        w_imm_sel  = IMM_NONE;
        w_wb_sel   = WB_ALU;
        w_jump_src = PCSRC_SEQ;
        case (w_class)
            CLS_OP_IMM: begin w_src2 = 1'b1; w_imm_sel = IMM_I; end
            CLS_LOAD:   begin w_src2 = 1'b1; w_imm_sel = IMM_I; w_wb_sel = WB_MEM; end
            CLS_STORE:  begin w_src2 = 1'b1; w_imm_sel = IMM_S; end
            CLS_BRANCH: begin w_imm_sel = IMM_B; end
            CLS_JAL:    begin w_imm_sel = IMM_J; w_wb_sel = WB_PC4; w_jump_src = PCSRC_BR; end
            CLS_JALR: begin
                w_src2     = 1'b1;
                w_imm_sel  = IMM_I;
                w_wb_sel   = WB_PC4;
                w_jump_src = PCSRC_ALU;
            end
            CLS_LUI:    begin w_src2 = 1'b1; w_imm_sel = IMM_U; end
            CLS_AUIPC:  begin w_src1 = 1'b1; w_src2 = 1'b1; w_imm_sel = IMM_U; end
            default: ;
        endcase
    end

    // Everything is gated by rst_i so a mid-operation reset drops requests without waiting for a clock.
    always_comb begin
        imem_req_o         = 1'b0;
        ir_load_o          = 1'b0;
        pc_write_o         = 1'b0;
        pc_src_o           = PCSRC_SEQ;
        reg_write_enable_o = 1'b0;
        wb_sel_o           = WB_ALU;
        alu_src_1_o        = 1'b0;
        alu_src_2_o        = 1'b0;
        imm_gen_sel_o      = IMM_NONE;
        alu_function_o     = ALU_NONE;
        dmem_req_o         = 1'b0;
        dmem_we_o          = 1'b0;
        dmem_size_o        = 3'd0;
        instr_retired_o    = 1'b0;
        if (rst_i) begin
            if (w_operands_on) begin
                alu_src_1_o    = w_src1;
                alu_src_2_o    = w_src2;
                imm_gen_sel_o  = w_imm_sel;
                alu_function_o = w_alu_fn;
            end
            case (r_state)
                ST_FETCH: begin
                    imem_req_o = 1'b1;
                    ir_load_o  = imem_valid_i;
                    pc_write_o = w_timeout;
                end
                ST_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
                    if (!w_legal) begin
                        pc_write_o      = 1'b1;
                        instr_retired_o = 1'b1;
                    end
`endif
                end
                ST_EXECUTE: begin
                    if (w_class == CLS_BRANCH) begin
                        pc_write_o      = 1'b1;
                        pc_src_o        = w_taken ? PCSRC_BR : PCSRC_SEQ;
                        instr_retired_o = 1'b1;
                    end else if (w_class == CLS_FENCE || w_class == CLS_SYSTEM) begin
                        pc_write_o      = 1'b1;
                        instr_retired_o = 1'b1;
                    end
                end
                ST_MEMORY: begin
                    dmem_req_o  = 1'b1;
                    dmem_we_o   = (w_class == CLS_STORE);
                    dmem_size_o = w_funct3;
                    if (dmem_ready_i) begin
                        if (w_class == CLS_STORE) begin
                            pc_write_o      = 1'b1;
                            instr_retired_o = 1'b1;
                        end
                    end else if (w_timeout) begin
                        pc_write_o = 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    reg_write_enable_o = 1'b1;
                    wb_sel_o           = w_wb_sel;
                    pc_write_o         = 1'b1;
                    pc_src_o           = w_jump_src;
                    instr_retired_o    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus_error_o = rst_i & (r_bus_error | w_timeout);
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_controller_multicycle.sv
// Directed bench for controller_multicycle: per-instruction latency, control pulses,
// memory waits, bus timeout, illegal handling and asynchronous reset.
module tb_controller_multicycle;
    import controller_multicycle_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] instruction_i = 32'd0;
    logic        zero_i = 1'b0;
    logic        lt_i = 1'b0;
    logic        imem_valid_i = 1'b0;
    logic        dmem_ready_i = 1'b0;
    logic        imem_req_o;
    logic        ir_load_o;
    logic        pc_write_o;
    logic [1:0]  pc_src_o;
    logic        reg_write_enable_o;
    logic [1:0]  wb_sel_o;
    logic        alu_src_1_o;
    logic        alu_src_2_o;
    logic [2:0]  imm_gen_sel_o;
    logic [3:0]  alu_function_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [2:0]  dmem_size_o;
    logic        instr_retired_o;
    logic        bus_error_o;
    logic [2:0]  dbg_state_o;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_o;
`endif

    controller_multicycle #(.MEM_TIMEOUT(16)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .instruction_i      (instruction_i),
        .zero_i             (zero_i),
        .lt_i               (lt_i),
        .imem_valid_i       (imem_valid_i),
        .dmem_ready_i       (dmem_ready_i),
        .imem_req_o         (imem_req_o),
        .ir_load_o          (ir_load_o),
        .pc_write_o         (pc_write_o),
        .pc_src_o           (pc_src_o),
        .reg_write_enable_o (reg_write_enable_o),
        .wb_sel_o           (wb_sel_o),
        .alu_src_1_o        (alu_src_1_o),
        .alu_src_2_o        (alu_src_2_o),
        .imm_gen_sel_o      (imm_gen_sel_o),
        .alu_function_o     (alu_function_o),
        .dmem_req_o         (dmem_req_o),
        .dmem_we_o          (dmem_we_o),
        .dmem_size_o        (dmem_size_o),
        .instr_retired_o    (instr_retired_o),
        .bus_error_o        (bus_error_o),
`ifdef ILLEGAL_TRAP_EN
        .illegal_o          (illegal_o),
`endif
        .dbg_state_o        (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_total = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    int          m_cyc, m_ret, m_rw, m_pcw, m_irl, m_dreq, m_dwe;
    logic [1:0]  m_pcsrc, m_wbsel;
    logic [3:0]  m_alu;
    logic        m_s1, m_s2, m_berr, m_done;
    logic [2:0]  m_imm, m_size;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one instruction from FETCH until its pc_write cycle. iw: fetch wait cycles,
    // dw: data wait cycles (-1 = never ready). Inputs change on the falling edge only.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                             input logic z, input logic l, input int exp_lat);
        int n_f;
        int n_m;
        exp_q.push_back(32'(exp_lat));
        instruction_i = ins;
        zero_i = z;
        lt_i = l;
        n_f = 0; n_m = 0;
        m_cyc = 0; m_ret = 0; m_rw = 0; m_pcw = 0; m_irl = 0; m_dreq = 0; m_dwe = 0;
        m_pcsrc = 2'd3; m_wbsel = 2'd3; m_alu = 4'hF; m_s1 = 1'bx; m_s2 = 1'bx;
        m_imm = 3'd7; m_size = 3'd7; m_berr = 1'b0; m_done = 1'b0;
        while (!m_done && m_cyc < 60) begin
            imem_valid_i = imem_req_o && (n_f >= iw);
            dmem_ready_i = dmem_req_o && (dw >= 0) && (n_m >= dw);
            #1;
            m_cyc++;
            if (imem_req_o) n_f++;
            if (dmem_req_o) begin
                n_m++;
                m_dreq++;
                m_size = dmem_size_o;
            end
            if (dmem_we_o) m_dwe++;
            if (ir_load_o) m_irl++;
            if (reg_write_enable_o) begin
                m_rw++;
                m_wbsel = wb_sel_o;
            end
            if (instr_retired_o) m_ret++;
            if (m_cyc == iw + 3) begin
                m_alu = alu_function_o;
                m_s1  = alu_src_1_o;
                m_s2  = alu_src_2_o;
                m_imm = imm_gen_sel_o;
            end
            if (pc_write_o) begin
                m_pcw++;
                m_pcsrc = pc_src_o;
                m_berr = bus_error_o;
                m_done = 1'b1;
            end
            @(negedge clk_i);
        end
        imem_valid_i = 1'b0;
        dmem_ready_i = 1'b0;
        chk("instr_end", 32'(m_done), 32'd1);
        chk("latency", 32'(m_cyc), exp_q.pop_front());
    endtask

    initial begin
        int rw_seen;

        // Reset state: everything quiet while rst_i is low.
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_imem_req", 32'(imem_req_o), 32'd0);
        chk("rst_pc_write", 32'(pc_write_o), 32'd0);
        chk("rst_bus_error", 32'(bus_error_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("rel_imem_req", 32'(imem_req_o), 32'd1);
        chk("rel_state", 32'(dbg_state_o), 32'd0);

        // addi x1,x0,5
        run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, 4);
        chk("addi_alu", 32'(m_alu), 32'(ALU_ADD));
        chk("addi_src2", 32'(m_s2), 32'd1);
        chk("addi_imm", 32'(m_imm), 32'(IMM_I));
        chk("addi_rw", 32'(m_rw), 32'd1);
        chk("addi_ret", 32'(m_ret), 32'd1);
        chk("addi_irl", 32'(m_irl), 32'd1);
        chk("addi_wb", 32'(m_wbsel), 32'(WB_ALU));

        // beq x0,x0,+8 taken and not taken
        run_instr(32'h00000463, 0, 0, 1'b1, 1'b0, 3);
        chk("beq_t_alu", 32'(m_alu), 32'(ALU_SUB));
        chk("beq_t_pcsrc", 32'(m_pcsrc), 32'(PCSRC_BR));
        chk("beq_t_ret", 32'(m_ret), 32'd1);
        chk("beq_t_rw", 32'(m_rw), 32'd0);
        chk("beq_t_imm", 32'(m_imm), 32'(IMM_B));
        run_instr(32'h00000463, 0, 0, 1'b0, 1'b0, 3);
        chk("beq_n_pcsrc", 32'(m_pcsrc), 32'(PCSRC_SEQ));

        // bltu taken on lt, bge not taken on lt
        run_instr(32'h00006463, 0, 0, 1'b0, 1'b1, 3);
        chk("bltu_alu", 32'(m_alu), 32'(ALU_SLTU));
        chk("bltu_pcsrc", 32'(m_pcsrc), 32'(PCSRC_BR));
        run_instr(32'h00005463, 0, 0, 1'b0, 1'b1, 3);
        chk("bge_alu", 32'(m_alu), 32'(ALU_SLT));
        chk("bge_pcsrc", 32'(m_pcsrc), 32'(PCSRC_SEQ));

        // lw x2,0(x1) with three data waits
        run_instr(32'h0000A103, 0, 3, 1'b0, 1'b0, 8);
        chk("lw_dreq", 32'(m_dreq), 32'd4);
        chk("lw_dwe", 32'(m_dwe), 32'd0);
        chk("lw_wb", 32'(m_wbsel), 32'(WB_MEM));
        chk("lw_rw", 32'(m_rw), 32'd1);
        chk("lw_size", 32'(m_size), 32'd2);
        chk("lw_alu", 32'(m_alu), 32'(ALU_ADD));

        // sw x2,4(x1) zero-wait
        run_instr(32'h0020A223, 0, 0, 1'b0, 1'b0, 4);
        chk("sw_dwe", 32'(m_dwe), 32'd1);
        chk("sw_rw", 32'(m_rw), 32'd0);
        chk("sw_ret", 32'(m_ret), 32'd1);
        chk("sw_imm", 32'(m_imm), 32'(IMM_S));

        // R-type variants
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, 4);
        chk("add_alu", 32'(m_alu), 32'(ALU_ADD));
        chk("add_src2", 32'(m_s2), 32'd0);
        run_instr(32'h402081B3, 0, 0, 1'b0, 1'b0, 4);
        chk("sub_alu", 32'(m_alu), 32'(ALU_SUB));
        run_instr(32'h0020F1B3, 0, 0, 1'b0, 1'b0, 4);
        chk("and_alu", 32'(m_alu), 32'(ALU_AND));

        // Jumps and upper immediates
        run_instr(32'h010000EF, 0, 0, 1'b0, 1'b0, 4);
        chk("jal_wb", 32'(m_wbsel), 32'(WB_PC4));
        chk("jal_pcsrc", 32'(m_pcsrc), 32'(PCSRC_BR));
        chk("jal_imm", 32'(m_imm), 32'(IMM_J));
        run_instr(32'h00008067, 0, 0, 1'b0, 1'b0, 4);
        chk("jalr_pcsrc", 32'(m_pcsrc), 32'(PCSRC_ALU));
        chk("jalr_wb", 32'(m_wbsel), 32'(WB_PC4));
        run_instr(32'h123452B7, 0, 0, 1'b0, 1'b0, 4);
        chk("lui_src1", 32'(m_s1), 32'd0);
        chk("lui_src2", 32'(m_s2), 32'd1);
        chk("lui_imm", 32'(m_imm), 32'(IMM_U));

        // ecall as NOP, then fetch with two instruction-memory waits
        run_instr(32'h00000073, 0, 0, 1'b0, 1'b0, 3);
        chk("ecall_ret", 32'(m_ret), 32'd1);
        chk("ecall_pcsrc", 32'(m_pcsrc), 32'(PCSRC_SEQ));
        run_instr(32'h00500093, 2, 0, 1'b0, 1'b0, 6);
        chk("iwait_rw", 32'(m_rw), 32'd1);
        chk("pre_tmo_berr", 32'(bus_error_o), 32'd0);

        // sw with the data bus never ready: times out on the 16th wait cycle
        run_instr(32'h0020A223, 0, -1, 1'b0, 1'b0, 19);
        chk("tmo_dreq", 32'(m_dreq), 32'd16);
        chk("tmo_ret", 32'(m_ret), 32'd0);
        chk("tmo_rw", 32'(m_rw), 32'd0);
        chk("tmo_pcsrc", 32'(m_pcsrc), 32'(PCSRC_SEQ));
        chk("tmo_berr", 32'(m_berr), 32'd1);
        #1;
        chk("tmo_fetch", 32'(imem_req_o), 32'd1);
        chk("tmo_sticky", 32'(bus_error_o), 32'd1);

        // All-zero word is illegal
`ifdef ILLEGAL_TRAP_EN
        instruction_i = 32'h00000000;
        imem_valid_i = 1'b1;
        @(negedge clk_i);
        imem_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #1;
        chk("trap_illegal", 32'(illegal_o), 32'd1);
        chk("trap_imem_req", 32'(imem_req_o), 32'd0);
        chk("trap_pc_write", 32'(pc_write_o), 32'd0);
        @(negedge clk_i);
`else
        run_instr(32'h00000000, 0, 0, 1'b0, 1'b0, 2);
        chk("ill_ret", 32'(m_ret), 32'd1);
        chk("ill_rw", 32'(m_rw), 32'd0);
        chk("ill_pcsrc", 32'(m_pcsrc), 32'(PCSRC_SEQ));
        #1;
        chk("ill_next_fetch", 32'(imem_req_o), 32'd1);
        @(negedge clk_i);
`endif

        // Reset asserted during a load's memory wait
        if (dbg_state_o != 3'd0) begin
            rst_i = 1'b0;
            @(negedge clk_i);
            rst_i = 1'b1;
        end
        instruction_i = 32'h0000A103;
        imem_valid_i = 1'b1;
        @(negedge clk_i);
        imem_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("mrst_pre_dreq", 32'(dmem_req_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("mrst_dreq", 32'(dmem_req_o), 32'd0);
        chk("mrst_rw", 32'(reg_write_enable_o), 32'd0);
        chk("mrst_pcw", 32'(pc_write_o), 32'd0);
        chk("mrst_berr", 32'(bus_error_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("mrst_rel_imem", 32'(imem_req_o), 32'd1);
        rw_seen = 0;
        repeat (5) begin
            @(negedge clk_i);
            #1;
            if (reg_write_enable_o) rw_seen++;
        end
        chk("mrst_no_rw", 32'(rw_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
